// File: rtl/data_ram_pkg.sv
// Shared types and elaboration helpers for the data RAM.
package data_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int bytes_of(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int lat_width(input int lat);
        return (lat <= 1) ? 1 : $clog2(lat + 1);
    endfunction

    // An access straddles a word when its highest enabled lane, shifted by
    // the byte offset, lands past the last lane of the word.
    function automatic bit is_split(input int o, input logic [63:0] be, input int nbytes);
        int hi;
        hi = -1;
        for (int i = 0; i < 64; i++) begin
            if ((i < nbytes) && be[i]) hi = i;
        end
        return (hi >= 0) && ((o + hi) >= nbytes);
    endfunction

endpackage

// File: rtl/data_ram_byte_rotate.sv
// Combinational byte-lane rotate. Left: lane i moves to lane (i+sh).
// Right: lane i takes lane (i+sh). BYTES must be a power of two.
module byte_rotate #(
    parameter int XLEN  = 32,
    parameter int BYTES = XLEN / 8,
    parameter int SW    = $clog2(BYTES)
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [SW-1:0]   i_sh,
    input  logic            i_left,
    output logic [XLEN-1:0] o_data
);

    // Per-lane source select for the chosen rotate direction.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < BYTES; i++) begin
            o_data[i*8 +: 8] = i_left ? i_data[((i + BYTES - int'(i_sh)) % BYTES)*8 +: 8]
                                      : i_data[((i + int'(i_sh)) % BYTES)*8 +: 8];
        end
    end

endmodule

// File: rtl/data_ram.sv
// Single-port data RAM with valid/ready request, per-beat wait states,
// range checking and two-beat splitting of word-straddling accesses.
// Splitting is enabled by defining DATA_RAM_MISALIGN_EN; otherwise a
// straddling request completes with rsp_err.
//
// state | meaning
// IDLE  | ready for a request
// BEAT0 | waiting, then accessing word w
// BEAT1 | waiting, then accessing word w+1 (split only)
// RESP  | one-cycle response pulse
module data_ram
    import data_ram_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rstl,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [XLEN-1:0]         req_addr,
    input  logic                    req_we,
    input  logic [bytes_of(XLEN)-1:0] req_be,
    input  logic [XLEN-1:0]         req_wdata,
    output logic                    rsp_valid,
    output logic [XLEN-1:0]         rsp_rdata,
    output logic                    rsp_err
);

    localparam int BYTES = bytes_of(XLEN);
    localparam int OW    = $clog2(BYTES);
    localparam int LW    = lat_width(LATENCY);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            r_state, w_next;
    logic [LW-1:0]     r_cnt, w_cnt_next;
    logic [XLEN-1:0]   r_addr, r_wdata, r_gather, r_rdata;
    logic [BYTES-1:0]  r_be;
    logic              r_we, r_rsp_err;
    logic [XLEN-1:0]   r_mem [DEPTH];

    logic              w_accept, w_beat_done, w_beat1;
    logic [XLEN-1:0]   w_cur_addr, w_cur_wdata, w_word, w_wrot, w_gather, w_rword, w_rrot;
    logic [BYTES-1:0]  w_cur_be, w_rot_be, w_lane;
    logic              w_cur_we, w_split_raw, w_oob, w_err, w_split;
    logic [OW-1:0]     w_o;
    logic [AW-1:0]     w_idx;

    // With zero wait states the first beat happens on the accept edge, so
    // the live request is used while idle and the latched copy afterwards.
    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_cur_be    = (r_state == IDLE) ? req_be    : r_be;
    assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    assign w_o         = w_cur_addr[OW-1:0];
    assign w_word      = w_cur_addr >> OW;
    assign w_split_raw = is_split(int'(w_o), 64'(w_cur_be), BYTES);
    assign w_oob       = (w_word >= XLEN'(DEPTH)) ||
                         (w_split_raw && (w_word >= XLEN'(DEPTH - 1)));
`ifdef DATA_RAM_MISALIGN_EN
    assign w_err   = (w_cur_be != '0) && w_oob;
    assign w_split = w_split_raw && !w_oob;
`else
    assign w_err   = (w_cur_be != '0) && (w_oob || w_split_raw);
    assign w_split = 1'b0;
`endif

    // Rotate byte enables into memory-lane order and pick this beat's lanes.
    always_comb begin
        w_rot_be = '0;
        w_lane   = '0;
        for (int j = 0; j < BYTES; j++) begin
            w_rot_be[j] = w_cur_be[(j + BYTES - int'(w_o)) % BYTES];
            w_lane[j]   = w_rot_be[j] && !w_err && w_beat_done &&
                          (w_beat1 ? (j < int'(w_o)) : (j >= int'(w_o)));
        end
    end

    assign w_idx   = w_word[AW-1:0] + AW'(w_beat1);
    assign w_rword = r_mem[w_idx];

    byte_rotate #(.XLEN(XLEN), .BYTES(BYTES), .SW(OW)) u_wr_rot (
        .i_data (w_cur_wdata),
        .i_sh   (w_o),
        .i_left (1'b1),
        .o_data (w_wrot)
    );

    // Merge this beat's read lanes onto the bytes gathered by earlier beats.
    always_comb begin
        w_gather = w_beat1 ? r_gather : '0;
        for (int j = 0; j < BYTES; j++) begin
            if (w_lane[j] && !w_cur_we) w_gather[j*8 +: 8] = w_rword[j*8 +: 8];
        end
    end

    byte_rotate #(.XLEN(XLEN), .BYTES(BYTES), .SW(OW)) u_rd_rot (
        .i_data (w_gather),
        .i_sh   (w_o),
        .i_left (1'b0),
        .o_data (w_rrot)
    );

    // Storage: per-byte writes at the edge that ends a beat; never reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < BYTES; j++) begin
            if (w_lane[j] && w_cur_we) r_mem[w_idx][j*8 +: 8] <= w_wrot[j*8 +: 8];
        end
    end

    // Next-state and beat timing; the second beat carries one extra cycle.
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_beat_done = 1'b0;
        w_beat1     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        w_beat_done = 1'b1;
                        w_next      = w_split ? BEAT1 : RESP;
                        w_cnt_next  = LW'(LATENCY);
                    end else begin
                        w_next     = BEAT0;
                        w_cnt_next = LW'(LATENCY - 1);
                    end
                end
            end
            BEAT0: begin
                if (r_cnt == '0) begin
                    w_beat_done = 1'b1;
                    w_next      = w_split ? BEAT1 : RESP;
                    w_cnt_next  = LW'(LATENCY);
                end else begin
                    w_cnt_next = r_cnt - LW'(1);
                end
            end
            BEAT1: begin
                w_beat1 = 1'b1;
                if (r_cnt == '0) begin
                    w_beat_done = 1'b1;
                    w_next      = RESP;
                end else begin
                    w_cnt_next = r_cnt - LW'(1);
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, request latch and response registers.
    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_gather  <= '0;
            r_rdata   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_be    <= req_be;
                r_wdata <= req_wdata;
            end
            if (w_beat_done) r_gather <= w_gather;
            if (w_beat_done && (w_next == RESP)) begin
                r_rdata   <= w_rrot;
                r_rsp_err <= w_err;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_rsp_err && rsp_valid;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: one LATENCY=1 and one LATENCY=0 instance.
module tb_data_ram;

    logic        clk = 1'b0;
    logic        rstl;
    logic        valid_a, valid_b;
    logic [31:0] addr, wdata;
    logic        we;
    logic [3:0]  be;
    logic        ready_a, rspv_a, err_a;
    logic [31:0] rdata_a;
    logic        ready_b, rspv_b, err_b;
    logic [31:0] rdata_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_ram #(.XLEN(32), .DEPTH(16), .LATENCY(1)) u_dut (
        .clk(clk), .rstl(rstl), .req_valid(valid_a), .req_ready(ready_a),
        .req_addr(addr), .req_we(we), .req_be(be), .req_wdata(wdata),
        .rsp_valid(rspv_a), .rsp_rdata(rdata_a), .rsp_err(err_a)
    );

    data_ram #(.XLEN(32), .DEPTH(16), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rstl(rstl), .req_valid(valid_b), .req_ready(ready_b),
        .req_addr(addr), .req_we(we), .req_be(be), .req_wdata(wdata),
        .rsp_valid(rspv_b), .rsp_rdata(rdata_b), .rsp_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request; lat = cycles from the accept edge to the rsp_valid cycle.
    task automatic do_req(input bit sb, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        addr = a; we = w; be = b; wdata = d;
        if (sb) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        lat = 99; rd = 'x; er = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((sb ? rspv_b : rspv_a) === 1'b1) begin
                lat = k;
                rd  = sb ? rdata_b : rdata_a;
                er  = sb ? err_b : err_a;
                break;
            end
        end
    endtask

    task automatic wr(input bit sb, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input int elat, input logic eerr, input string tag);
        int lat; logic [31:0] rd; logic er;
        do_req(sb, a, 1'b1, b, d, lat, rd, er);
        chk({tag, " lat"}, 32'(lat), 32'(elat));
        chk({tag, " err"}, 32'(er), 32'(eerr));
    endtask

    task automatic rdc(input bit sb, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] edata, input int elat, input logic eerr, input string tag);
        int lat; logic [31:0] rd; logic er;
        do_req(sb, a, 1'b0, b, 32'h0, lat, rd, er);
        chk({tag, " lat"},  32'(lat), 32'(elat));
        chk({tag, " err"},  32'(er), 32'(eerr));
        chk({tag, " data"}, rd, edata);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_k, rdy_k, lat;
        logic [31:0] rd1, rd;
        logic seen, er, pulse_after;

        rstl = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        addr = '0; we = 1'b0; be = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst ready",  32'(ready_a), 32'h1);
        chk("rst rspv",   32'(rspv_a),  32'h0);
        chk("rst rdata",  rdata_a,      32'h0);
        chk("rst err",    32'(err_a),   32'h0);
        chk("rst rspv l0", 32'(rspv_b), 32'h0);
        rstl = 1'b1;

        // Aligned write, then partial reads
        wr (0, 32'd0, 4'b1111, 32'hFFFFFC18, 2, 1'b0, "w0");
        rdc(0, 32'd0, 4'b0001, 32'h00000018, 2, 1'b0, "r0 be1");
        rdc(0, 32'd0, 4'b0011, 32'h0000FC18, 2, 1'b0, "r0 be3");
        rdc(0, 32'd0, 4'b1111, 32'hFFFFFC18, 2, 1'b0, "r0 beF");

        // Range errors
        wr (0, 32'd60, 4'b1111, 32'h5A5A5A5A, 2, 1'b0, "w15");
        wr (0, 32'd64, 4'b1111, 32'hDEADBEEF, 2, 1'b1, "w64 oob");
        wr (0, 32'd62, 4'b1111, 32'hCAFEF00D, 2, 1'b1, "w62 oob");
        rdc(0, 32'd60, 4'b1111, 32'h5A5A5A5A, 2, 1'b0, "r15 intact");
        rdc(0, 32'd64, 4'b1111, 32'h00000000, 2, 1'b1, "r64 oob");
        rdc(0, 32'd64, 4'b0000, 32'h00000000, 2, 1'b0, "r64 be0");

`ifdef DATA_RAM_MISALIGN_EN
        // Split write and read
        wr (0, 32'd4, 4'b1111, 32'h0, 2, 1'b0, "z1");
        wr (0, 32'd8, 4'b1111, 32'h0, 2, 1'b0, "z2");
        wr (0, 32'd6, 4'b1111, 32'h11223344, 4, 1'b0, "w6 split");
        rdc(0, 32'd4, 4'b1111, 32'h33440000, 2, 1'b0, "r4");
        rdc(0, 32'd8, 4'b1111, 32'h00001122, 2, 1'b0, "r8");
        rdc(0, 32'd6, 4'b1111, 32'h11223344, 4, 1'b0, "r6 split");

        // Reset between the two beats of a split write
        wr (0, 32'd4, 4'b1111, 32'h0, 2, 1'b0, "z1b");
        wr (0, 32'd8, 4'b1111, 32'h0, 2, 1'b0, "z2b");
        @(negedge clk);
        addr = 32'd6; we = 1'b1; be = 4'b1111; wdata = 32'hAABBCCDD; valid_a = 1'b1;
        @(posedge clk);
        #1 valid_a = 1'b0;
        seen = 1'b0;
        @(negedge clk); seen |= rspv_a;
        @(negedge clk); rstl = 1'b0;
        @(negedge clk); seen |= rspv_a;
        @(negedge clk); rstl = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); seen |= rspv_a;
        end
        chk("rst mid rspv",  32'(seen),    32'h0);
        chk("rst mid ready", 32'(ready_a), 32'h1);
        rdc(0, 32'd4, 4'b1111, 32'hCCDD0000, 2, 1'b0, "r4 after rst");
        rdc(0, 32'd8, 4'b1111, 32'h00000000, 2, 1'b0, "r8 after rst");
`else
        // Straddling request rejected; in-word offsets still legal
        wr (0, 32'd4, 4'b1111, 32'h0, 2, 1'b0, "z1");
        wr (0, 32'd8, 4'b1111, 32'h0, 2, 1'b0, "z2");
        wr (0, 32'd6, 4'b1111, 32'h11223344, 2, 1'b1, "w6 straddle");
        rdc(0, 32'd4, 4'b1111, 32'h00000000, 2, 1'b0, "r4 nowrite");
        rdc(0, 32'd8, 4'b1111, 32'h00000000, 2, 1'b0, "r8 nowrite");
        rdc(0, 32'd6, 4'b1111, 32'h00000000, 2, 1'b1, "r6 straddle");
        wr (0, 32'd5, 4'b0001, 32'h0000007F, 2, 1'b0, "w5");
        rdc(0, 32'd5, 4'b0001, 32'h0000007F, 2, 1'b0, "r5");
        wr (0, 32'd7, 4'b0001, 32'h000000A5, 2, 1'b0, "w7");
        rdc(0, 32'd4, 4'b1111, 32'hA5007F00, 2, 1'b0, "r4 word");
        rdc(0, 32'd6, 4'b0011, 32'h0000A500, 2, 1'b0, "r6 be3");
        rdc(0, 32'd5, 4'b0011, 32'h0000007F, 2, 1'b0, "r5 be3");
`endif

        // be == 0 clears rdata
        rdc(0, 32'd0, 4'b0000, 32'h00000000, 2, 1'b0, "r be0");

        // req_valid held high: second accept three cycles after the first
        @(negedge clk);
        addr = 32'd0; we = 1'b0; be = 4'b1111; valid_a = 1'b1;
        @(posedge clk);
        rsp_k = 99; rdy_k = 99; rd1 = 'x; pulse_after = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rspv_a === 1'b1) begin rsp_k = k; rd1 = rdata_a; end
            if (ready_a === 1'b1) begin rdy_k = k; pulse_after = rspv_a; break; end
        end
        addr = 32'd60;
        @(posedge clk);
        #1 valid_a = 1'b0;
        lat = 99; rd = 'x; er = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rspv_a === 1'b1) begin lat = k; rd = rdata_a; er = err_a; break; end
        end
        chk("b2b rsp1 lat",   32'(rsp_k), 32'd2);
        chk("b2b rsp1 data",  rd1,        32'hFFFFFC18);
        chk("b2b accept2",    32'(rdy_k), 32'd3);
        chk("b2b rsp pulse",  32'(pulse_after), 32'h0);
        chk("b2b rsp2 lat",   32'(lat),   32'd2);
        chk("b2b rsp2 data",  rd,         32'h5A5A5A5A);
        chk("b2b rsp2 err",   32'(er),    32'h0);

        // Zero wait states
        wr (1, 32'd0, 4'b1111, 32'h13579BDF, 1, 1'b0, "l0 w0");
        rdc(1, 32'd0, 4'b1111, 32'h13579BDF, 1, 1'b0, "l0 r0");
        wr (1, 32'd3, 4'b0001, 32'h000000EE, 1, 1'b0, "l0 w3");
        rdc(1, 32'd0, 4'b1111, 32'hEE579BDF, 1, 1'b0, "l0 r0 b");
`ifdef DATA_RAM_MISALIGN_EN
        wr (1, 32'd4, 4'b1111, 32'h0, 1, 1'b0, "l0 z1");
        wr (1, 32'd2, 4'b1111, 32'h01020304, 2, 1'b0, "l0 w2 split");
        rdc(1, 32'd0, 4'b1111, 32'h03049BDF, 1, 1'b0, "l0 r0 c");
        rdc(1, 32'd4, 4'b1111, 32'h00000102, 1, 1'b0, "l0 r4");
`else
        wr (1, 32'd2, 4'b1111, 32'h01020304, 1, 1'b1, "l0 w2 straddle");
        rdc(1, 32'd0, 4'b1111, 32'hEE579BDF, 1, 1'b0, "l0 r0 c");
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
